// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if: valid/ready operand and result bus for fp_mul_pipe
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = EXP_W + MAN_W + 1;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] fp_X;
  logic [W-1:0] fp_Y;
  logic [2:0]   r_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] fp_Z;
  logic         ovrf;
  logic         udrf;
  modport master (
    output in_valid, fp_X, fp_Y, r_mode, out_ready,
    input  in_ready, out_valid, fp_Z, ovrf, udrf
  );
  modport slave (
    input  in_valid, fp_X, fp_Y, r_mode, out_ready,
    output in_ready, out_valid, fp_Z, ovrf, udrf
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: parametrised pipelined floating-point multiplier with valid/ready stall
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic        clk,
  input logic        rst,
  fp_mul_pipe_if.slave bus
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0] EMAX  = '1;
  localparam logic [EXP_W-1:0] EMAXF = EMAX - 1'b1;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EOVF = EW'((1 << EXP_W) - 1);
  localparam logic [1:0] K_NUM = 2'd0, K_NAN = 2'd1, K_INF = 2'd2, K_ZERO = 2'd3;

  logic w_adv;
  assign w_adv = !bus.out_valid || bus.out_ready;

  logic         r_v0;
  logic [W-1:0] r_x0, r_y0;
  logic [2:0]   r_m0;

  logic               w_sx, w_sy;
  logic [EXP_W-1:0]   w_ex, w_ey;
  logic [MAN_W-1:0]   w_fx, w_fy;
  logic               w_nx, w_ny, w_ix, w_iy, w_zx, w_zy;
  logic [1:0]         w_kind;
  logic signed [EW-1:0] w_esum;
  logic [PW-1:0]      w_prod;
  assign {w_sx, w_ex, w_fx} = r_x0;
  assign {w_sy, w_ey, w_fy} = r_y0;
  assign w_nx = (w_ex == EMAX) && (w_fx != '0);
  assign w_ny = (w_ey == EMAX) && (w_fy != '0);
  assign w_ix = (w_ex == EMAX) && (w_fx == '0);
  assign w_iy = (w_ey == EMAX) && (w_fy == '0);
  assign w_zx = w_ex == '0;
  assign w_zy = w_ey == '0;
  assign w_kind = (w_nx || w_ny || (w_ix && w_zy) || (w_iy && w_zx)) ? K_NAN
                : (w_ix || w_iy) ? K_INF
                : (w_zx || w_zy) ? K_ZERO : K_NUM;
  assign w_esum = EW'(w_ex) + EW'(w_ey) - BIAS;
  assign w_prod = PW'({1'b1, w_fx}) * PW'({1'b1, w_fy});

  logic                 r_v1, r_s1;
  logic [1:0]           r_k1;
  logic signed [EW-1:0] r_e1;
  logic [PW-1:0]        r_p1;
  logic [2:0]           r_m1;

  // product is in [1,4); shift so the leading one sits at PW-1 and drop it
  logic                 w_hi;
  logic [PW-2:0]        w_norm;
  logic signed [EW-1:0] w_e2;
  assign w_hi   = r_p1[PW-1];
  assign w_norm = w_hi ? r_p1[PW-2:0] : {r_p1[PW-3:0], 1'b0};
  assign w_e2   = r_e1 + EW'(w_hi);

  logic                 r_v2, r_s2, r_g2, r_r2, r_t2;
  logic [1:0]           r_k2;
  logic signed [EW-1:0] r_e2;
  logic [MAN_W-1:0]     r_f2;
  logic [2:0]           r_m2;

  logic                 w_rne, w_rmm, w_rdn, w_rup, w_any, w_inc, w_ov, w_un, w_toinf;
  logic [MAN_W:0]       w_fr;
  logic signed [EW-1:0] w_ef;
  logic [W-1:0]         w_z;
  assign w_rne   = (r_m2 == 3'd0) || (r_m2 > 3'd4);
  assign w_rmm   = r_m2 == 3'd4;
  assign w_rdn   = r_m2 == 3'd2;
  assign w_rup   = r_m2 == 3'd3;
  assign w_any   = r_g2 || r_r2 || r_t2;
  assign w_inc   = w_rne ? (r_g2 && (r_r2 || r_t2 || r_f2[0]))
                 : w_rmm ? r_g2
                 : w_rdn ? (r_s2 && w_any)
                 : w_rup ? (!r_s2 && w_any) : 1'b0;
  assign w_fr    = {1'b0, r_f2} + (MAN_W + 1)'(w_inc);
  assign w_ef    = r_e2 + EW'(w_fr[MAN_W]);
  assign w_ov    = w_ef >= EOVF;
  assign w_un    = w_ef[EW-1] || (w_ef == '0);
  assign w_toinf = w_rne || w_rmm || (w_rdn && r_s2) || (w_rup && !r_s2);
  assign w_z = (r_k2 == K_NAN) ? {1'b0, EMAX, 1'b1, {(MAN_W - 1){1'b0}}}
             : (r_k2 == K_INF) ? {r_s2, EMAX, {MAN_W{1'b0}}}
             : ((r_k2 == K_ZERO) || w_un) ? {r_s2, {(W - 1){1'b0}}}
             : w_ov ? (w_toinf ? {r_s2, EMAX, {MAN_W{1'b0}}} : {r_s2, EMAXF, {MAN_W{1'b1}}})
             : {r_s2, w_ef[EXP_W-1:0], w_fr[MAN_W-1:0]};

  logic         r_v3, r_ov, r_ud;
  logic [W-1:0] r_z;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_z  <= '0;
      r_ov <= 1'b0;
      r_ud <= 1'b0;
    end else if (w_adv) begin
      r_v0 <= bus.in_valid;
      r_x0 <= bus.fp_X;
      r_y0 <= bus.fp_Y;
      r_m0 <= bus.r_mode;
      r_v1 <= r_v0;
      r_s1 <= w_sx ^ w_sy;
      r_k1 <= w_kind;
      r_e1 <= w_esum;
      r_p1 <= w_prod;
      r_m1 <= r_m0;
      r_v2 <= r_v1;
      r_s2 <= r_s1;
      r_k2 <= r_k1;
      r_e2 <= w_e2;
      r_f2 <= w_norm[PW-2 -: MAN_W];
      r_g2 <= w_norm[MAN_W];
      r_r2 <= w_norm[MAN_W-1];
      r_t2 <= |w_norm[MAN_W-2:0];
      r_m2 <= r_m1;
      r_v3 <= r_v2;
      if (r_v2) begin
        r_z  <= w_z;
        r_ov <= (r_k2 == K_NUM) && w_ov;
        r_ud <= (r_k2 == K_NUM) && w_un;
      end
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_v3;
  assign bus.fp_Z      = r_z;
  assign bus.ovrf      = r_ov;
  assign bus.udrf      = r_ud;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed and randomized checks of fp_mul_pipe against an exact-arithmetic model
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) a();
  fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10)) b();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) u_a (.clk(clk), .rst(rst), .bus(a));
  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_b (.clk(clk), .rst(rst), .bus(b));

  localparam int NV = 15;
  localparam logic [31:0] VX [NV] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'hBF800001,
                                      32'h7F000000, 32'h7F000000, 32'hFF000000, 32'h00800000, 32'h7F800000,
                                      32'h7FC00001, 32'h00000001, 32'h3F800001, 32'h3F800003, 32'h3F800003};
  localparam logic [31:0] VY [NV] = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001,
                                      32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h3F000000, 32'h00000000,
                                      32'h3F800000, 32'h7F000000, 32'h3F800001, 32'h3F400000, 32'h3F400000};
  localparam logic [2:0]  VM [NV] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd1, 3'd3, 3'd0, 3'd0,
                                      3'd0, 3'd0, 3'd4, 3'd0, 3'd4};
  localparam logic [31:0] VZ [NV] = '{32'h40400000, 32'h3F800002, 32'h3F800002, 32'h3F800003, 32'hBF800003,
                                      32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00000000, 32'h7FC00000,
                                      32'h7FC00000, 32'h00000000, 32'h3F800002, 32'h3F400004, 32'h3F400005};
  localparam logic [1:0]  VF [NV] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0,
                                      2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

  // exact integer product, rounded by comparing the discarded part against one half-ulp
  function automatic logic [33:0] ref_mul(input int ew, input int mw, input logic [31:0] x,
                                          input logic [31:0] y, input logic [2:0] md);
    longint one, emax, bias, ex, ey, fx, fy, p, e, q, rem, half, sh, sgn;
    logic s, nx, ny, ix, iy, zx, zy, inc, ov, ud;
    logic [2:0] m;
    logic [31:0] z;
    one  = 1;
    emax = (one << ew) - 1;
    bias = (one << (ew - 1)) - 1;
    ex = longint'(x >> mw) & emax;
    ey = longint'(y >> mw) & emax;
    fx = longint'(x) & ((one << mw) - 1);
    fy = longint'(y) & ((one << mw) - 1);
    s  = x[ew+mw] ^ y[ew+mw];
    sgn = longint'(s) << (ew + mw);
    nx = ex == emax && fx != 0;
    ny = ey == emax && fy != 0;
    ix = ex == emax && fx == 0;
    iy = ey == emax && fy == 0;
    zx = ex == 0;
    zy = ey == 0;
    m  = (md > 3'd4) ? 3'd0 : md;
    ov = 1'b0;
    ud = 1'b0;
    inc = 1'b0;
    if (nx || ny || (ix && zy) || (iy && zx)) z = 32'((emax << mw) | (one << (mw - 1)));
    else if (ix || iy) z = 32'(sgn | (emax << mw));
    else if (zx || zy) z = 32'(sgn);
    else begin
      p  = ((one << mw) | fx) * ((one << mw) | fy);
      e  = ex + ey - bias;
      sh = mw;
      if (p >= (one << (2 * mw + 1))) begin
        sh = mw + 1;
        e  = e + 1;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = one << (sh - 1);
      case (m)
        3'd0:    inc = (rem > half) || (rem == half && q[0]);
        3'd1:    inc = 1'b0;
        3'd2:    inc = s && rem != 0;
        3'd3:    inc = !s && rem != 0;
        default: inc = rem >= half;
      endcase
      q = q + longint'(inc);
      if (q == (one << (mw + 1))) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= emax) begin
        ov = 1'b1;
        z = (m == 3'd0 || m == 3'd4 || (m == 3'd2 && s) || (m == 3'd3 && !s))
          ? 32'(sgn | (emax << mw))
          : 32'(sgn | ((emax - 1) << mw) | ((one << mw) - 1));
      end else if (e <= 0) begin
        ud = 1'b1;
        z = 32'(sgn);
      end else z = 32'(sgn | (e << mw) | (q & ((one << mw) - 1)));
    end
    return {ov, ud, z};
  endfunction

  function automatic logic [31:0] rnd_op;
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k < 6) v[30:23] = 8'($urandom_range(100, 154));
    else if (k == 6) v[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
    else if (k == 7) v[30:0] = ($urandom_range(0, 1) != 0) ? 31'h7F800000 : 31'h0;
    else if (k == 8) begin
      v[30:23] = 8'($urandom_range(110, 144));
      v[11:0]  = 12'h0;
    end
    return v;
  endfunction

  task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                      output logic [33:0] r, output int lat);
    @(negedge clk);
    a.in_valid = 1'b1; a.fp_X = x; a.fp_Y = y; a.r_mode = m; a.out_ready = 1'b1;
    @(negedge clk);
    a.in_valid = 1'b0;
    lat = 0;
    while (!a.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    r = {a.ovrf, a.udrf, a.fp_Z};
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic [2:0] m,
                      output logic [17:0] r, output int lat);
    @(negedge clk);
    b.in_valid = 1'b1; b.fp_X = x; b.fp_Y = y; b.r_mode = m; b.out_ready = 1'b1;
    @(negedge clk);
    b.in_valid = 1'b0;
    lat = 0;
    while (!b.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    r = {b.ovrf, b.udrf, b.fp_Z};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (a.out_valid !== 1'b0 || a.fp_Z !== 32'h0 || a.ovrf !== 1'b0 || a.udrf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got v=%b z=%h o=%b u=%b want v=0 z=0 o=0 u=0", a.out_valid, a.fp_Z, a.ovrf, a.udrf);
    end
    total++;
    if (b.out_valid !== 1'b0 || b.fp_Z !== 16'h0) begin
      bad++;
      $display("FAIL reset_state16 got v=%b z=%h want v=0 z=0", b.out_valid, b.fp_Z);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (a.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", a.in_ready);
    end
  endtask

  task automatic test_basic;
    logic [33:0] r;
    int lat;
    for (int i = 0; i < NV; i++) begin
      op32(VX[i], VY[i], VM[i], r, lat);
      total++;
      if (r !== {VF[i], VZ[i]} || lat !== 3) begin
        bad++;
        $display("FAIL basic_%0d got z=%h of=%b lat=%0d want z=%h of=%b lat=3", i, r[31:0], r[33:32], lat, VZ[i], VF[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [33:0] q[$];
    logic [33:0] want;
    logic [31:0] cx, cy;
    logic [2:0] cm;
    int sent = 0;
    int got = 0;
    cx = rnd_op(); cy = rnd_op(); cm = 3'($urandom_range(0, 7));
    for (int cyc = 0; cyc < 5000 && got < 300; cyc++) begin
      @(negedge clk);
      a.in_valid = sent < 300 && $urandom_range(0, 3) != 0;
      a.fp_X = cx; a.fp_Y = cy; a.r_mode = cm;
      a.out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (a.out_valid && a.out_ready) begin
        got++;
        want = 'x;
        if (q.size() != 0) want = q.pop_front();
        total++;
        if ({a.ovrf, a.udrf, a.fp_Z} !== want) begin
          bad++;
          $display("FAIL random_%0d got z=%h of=%b want z=%h of=%b", got, a.fp_Z, {a.ovrf, a.udrf}, want[31:0], want[33:32]);
        end
      end
      if (a.in_valid && a.in_ready) begin
        q.push_back(ref_mul(8, 23, cx, cy, cm));
        sent++;
        cx = rnd_op(); cy = rnd_op(); cm = 3'($urandom_range(0, 7));
      end
    end
    total++;
    if (got != 300) begin
      bad++;
      $display("FAIL random_count got=%0d want=300", got);
    end
    a.in_valid = 1'b0;
    a.out_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [33:0] q[$];
    logic [33:0] want;
    logic [31:0] held;
    logic [31:0] cx, cy;
    logic [2:0] cm;
    int sent = 0;
    int got = 0;
    int last = -1;
    held = '0;
    cx = rnd_op(); cy = rnd_op(); cm = 3'($urandom_range(0, 4));
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      a.in_valid = sent < 8;
      a.fp_X = cx; a.fp_Y = cy; a.r_mode = cm;
      a.out_ready = !(cyc >= 5 && cyc < 9);
      #1;
      if (cyc == 5) held = a.fp_Z;
      if (cyc >= 5 && cyc < 9) begin
        total++;
        if (a.in_ready !== 1'b0 || a.out_valid !== 1'b1) begin
          bad++;
          $display("FAIL stall_ready cyc=%0d got in_ready=%b out_valid=%b want 0 1", cyc, a.in_ready, a.out_valid);
        end
      end
      if (cyc > 5 && cyc < 9) begin
        total++;
        if (a.fp_Z !== held) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, a.fp_Z, held);
        end
      end
      if (a.out_valid && a.out_ready) begin
        got++;
        want = 'x;
        if (q.size() != 0) want = q.pop_front();
        total++;
        if ({a.ovrf, a.udrf, a.fp_Z} !== want) begin
          bad++;
          $display("FAIL b2b_order_%0d got z=%h of=%b want z=%h of=%b", got, a.fp_Z, {a.ovrf, a.udrf}, want[31:0], want[33:32]);
        end
        if (cyc > 9) begin
          total++;
          if (cyc - last != 1) begin
            bad++;
            $display("FAIL b2b_rate got gap=%0d want=1", cyc - last);
          end
        end
        last = cyc;
      end
      if (a.in_valid && a.in_ready) begin
        q.push_back(ref_mul(8, 23, cx, cy, cm));
        sent++;
        cx = rnd_op(); cy = rnd_op(); cm = 3'($urandom_range(0, 4));
      end
    end
    total++;
    if (got != 8 || q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count got=%0d left=%0d want=8 left=0", got, q.size());
    end
    a.in_valid = 1'b0;
    a.out_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    logic [33:0] r;
    int lat;
    int seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a.in_valid = 1'b1; a.fp_X = 32'h3F800000 + 32'(i); a.fp_Y = 32'h40400000; a.r_mode = 3'd0;
      a.out_ready = 1'b1;
    end
    @(negedge clk);
    a.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (a.out_valid !== 1'b0 || a.fp_Z !== 32'h0 || a.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_state got v=%b z=%h rdy=%b want v=0 z=0 rdy=1", a.out_valid, a.fp_Z, a.in_ready);
    end
    repeat (6) begin
      @(negedge clk);
      if (a.out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_leak got=%0d results want=0", seen);
    end
    op32(32'h3FC00000, 32'h40000000, 3'd0, r, lat);
    total++;
    if (r !== {2'b00, 32'h40400000} || lat !== 3) begin
      bad++;
      $display("FAIL midreset_next got z=%h of=%b lat=%0d want z=40400000 of=00 lat=3", r[31:0], r[33:32], lat);
    end
  endtask

  task automatic test_param;
    logic [17:0] r;
    logic [33:0] m;
    logic [15:0] x, y;
    logic [2:0] md;
    int lat;
    op16(16'h3E00, 16'h4000, 3'd0, r, lat);
    total++;
    if (r !== {2'b00, 16'h4200} || lat !== 3) begin
      bad++;
      $display("FAIL p16_basic got z=%h of=%b lat=%0d want z=4200 of=00 lat=3", r[15:0], r[17:16], lat);
    end
    op16(16'h7800, 16'h7800, 3'd0, r, lat);
    total++;
    if (r !== {2'b10, 16'h7C00}) begin
      bad++;
      $display("FAIL p16_ovf got z=%h of=%b want z=7c00 of=10", r[15:0], r[17:16]);
    end
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom); y = 16'($urandom); md = 3'($urandom_range(0, 7));
      if (i % 4 != 0) begin
        x[14:10] = 5'($urandom_range(8, 22));
        y[14:10] = 5'($urandom_range(8, 22));
      end
      m = ref_mul(5, 10, {16'h0, x}, {16'h0, y}, md);
      op16(x, y, md, r, lat);
      total++;
      if (r !== {m[33:32], m[15:0]}) begin
        bad++;
        $display("FAIL p16_rand_%0d x=%h y=%h m=%0d got z=%h of=%b want z=%h of=%b", i, x, y, md, r[15:0], r[17:16], m[15:0], m[33:32]);
      end
    end
  endtask

  initial begin
    a.in_valid = 1'b0; a.fp_X = '0; a.fp_Y = '0; a.r_mode = 3'd0; a.out_ready = 1'b1;
    b.in_valid = 1'b0; b.fp_X = '0; b.fp_Y = '0; b.r_mode = 3'd0; b.out_ready = 1'b1;
    test_reset;
    test_basic;
    test_random;
    test_back_to_back;
    test_reset_midflight;
    test_param;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier, successor to the fixed single-precision multiplier.
- Generalised exponent and mantissa widths.
- Adds valid/ready flow control with full-pipeline stall and a fifth rounding mode (RMM).
- Sits between the operand sequencer and the result collector; throughput is one product per cycle when not back-pressured.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored mantissa width (hidden bit excluded).
- W, EXP_W+MAN_W+1, total word width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and r_mode valid.
- in_ready  out  1  block accepts operands this cycle.
- fp_X  in  W  operand X {sign, exp, man}.
- fp_Y  in  W  operand Y.
- r_mode  in  3  rounding: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE.
- out_valid  out  1  fp_Z and flags valid.
- out_ready  in  1  consumer accepts the result.
- fp_Z  out  W  product.
- ovrf  out  1  overflow flag for this result.
- udrf  out  1  underflow flag for this result.

Behaviour:
- Reset: all stage valid bits cleared; fp_Z=0, ovrf=0, udrf=0, out_valid=0. Reset mid-operation discards every in-flight operand. in_ready is 1 in the cycle after rst deasserts.
- Pipeline: 3 stages.
  - S1: unpack, classify, exponent add, (MAN_W+1)x(MAN_W+1) mantissa multiply.
  - S2: normalise by 0 or 1 bit; form guard, round and sticky bits.
  - S3: round, handle overflow/underflow, pack.
- Latency: a transfer accepted at edge N produces out_valid=1 after edge N+3 if there is no stall.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv.
  - The input transfers when in_valid & in_ready; the output transfers when out_valid & out_ready.
  - When adv=0, all stages hold: no register changes, and fp_Z and the flags remain stable.
  - Bubbles propagate as invalid stages; bubbles do not collapse while stalled.
- Subnormal inputs (exp=0) are treated as signed zero (DAZ). Outputs are never subnormal.
- Sign = sX ^ sY in all non-NaN cases.
- Specials, evaluated in this priority order; ovrf=udrf=0 for all of them:
  - Any NaN operand, or Inf x 0 → canonical qNaN: sign 0, exp all ones, man = 1 followed by zeros.
  - Inf x (finite or Inf) → signed Inf.
  - 0 x finite → signed zero.
- Exponent arithmetic: unbiased sum eX+eY-bias, computed in EXP_W+2-bit signed width. Add 1 if the product is at least 2.0. Add 1 if rounding carries out of the mantissa.
- Rounding uses G, R, and S (S = OR of all lower bits):
  - RNE: increment if G & (R|S|lsb).
  - RTZ: never increment.
  - RDN: increment if sign & (G|R|S).
  - RUP: increment if !sign & (G|R|S).
  - RMM: increment if G.
- Overflow: the final biased exponent is at least 2^EXP_W-1. Set ovrf=1. Result depends on mode:
  - RNE, RMM: signed Inf.
  - RTZ: signed max-finite.
  - RDN: -Inf if negative, +max-finite if positive.
  - RUP: +Inf if positive, -max-finite if negative.
- Underflow: the final biased exponent after rounding is at most 0. The result is signed zero and udrf=1.
- Flags are per-result. They are registered in S3 alongside fp_Z and are valid only while out_valid=1.
- r_mode is sampled with its operands and travels down the pipe. Per-operation mode changes are legal back-to-back.

Test Plan:
- Basic, RNE: 0x3FC00000 x 0x40000000 → 0x40400000, ovrf=0, udrf=0, out_valid exactly 3 cycles after acceptance.
- Rounding: 0x3F800001 x 0x3F800001 gives:
  - RNE or RTZ → 0x3F800002.
  - RUP → 0x3F800003.
  - RDN with sign X=1 (0xBF800001 x 0x3F800001) → 0xBF800003.
- Overflow: 0x7F000000 x 0x7F000000 gives:
  - RNE → 0x7F800000, ovrf=1.
  - RTZ → 0x7F7FFFFF, ovrf=1.
  - Negated X under RUP → 0xFF7FFFFF, ovrf=1.
- Underflow and specials:
  - 0x00800000 x 0x3F000000 → 0x00000000, udrf=1.
  - 0x7F800000 x 0x00000000 → 0x7FC00000, no flags.
  - 0x7FC00001 x 0x3F800000 → 0x7FC00000.
  - 0x00000001 x 0x7F000000 → 0x00000000, udrf=0 (DAZ).
- Back-pressure: stream 8 back-to-back operations, holding out_ready=0 for 4 cycles mid-stream. The bench checks:
  - in_ready falls in the same cycle.
  - fp_Z is held stable.
  - No result is lost or duplicated, and order is preserved.
  - Throughput is 1 per cycle after release.
- Reset mid-flight: accept 3 operations, then assert rst for 1 cycle. The bench checks that no result of those 3 appears, out_valid=0, fp_Z=0, and the next operation after reset completes with 3-cycle latency.
- Parameter sweep: EXP_W=5, MAN_W=10. Check 0x3E00 x 0x4000 → 0x4200 and 0x7800 x 0x7800 under RNE → 0x7C00, ovrf=1.
